// File: rtl/fp_normalize_round.sv
`default_nettype none
// ============================================================================
// Module   : fp_normalize_round
// Purpose  : Normalize-and-round stage of the FP adder datapath. It takes the
//            aligned ALU sum and produces the sign, biased exponent and
//            23-bit fraction for the pack stage. Rounding is
//            round-to-nearest-even. There are valid/ready handshakes on both
//            sides, and at most one operation is in flight.
// Options  : FPNORM_FAST_SHIFT_EN - when defined, left normalization uses a
//            leading-zero count and completes in a single SHIFT cycle.
//            Results are the same as the one-bit-per-cycle default.
// Revision : 1.0 - initial release
// ============================================================================
module fp_normalize_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] alignedResult,
  input  logic        carryOut,
  input  logic        alignedSign,
  input  logic [7:0]  exponentOut,
  input  logic        guardBit,
  input  logic        roundBit,
  input  logic        stickyBit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        normalizedSign,
  output logic [7:0]  normalizedExponent,
  output logic [22:0] normalizedMantissa,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  // The carry is resolved when an operand is accepted. Only {mant[23:0], G, R, S} is kept.
  logic [26:0]       work;
  logic signed [9:0] exp_q;
  logic              sign_q;

  logic              accept;
  logic [7:0]        exp_in8;
  logic signed [9:0] exp_in;
  logic              is_special;
  logic              is_zero;
  logic [26:0]       work_load;
  logic signed [9:0] exp_load;
  logic              load_norm;

  logic [26:0]       work_shift;
  logic signed [9:0] exp_shift;
  logic              shift_done;

  logic [23:0]       mant;
  logic              round_up;
  logic              inexact;
  logic [24:0]       sum;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_r;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  // Decode an incoming operand into working-register form (subnormal exp 0 acts as 1)
  always_comb begin
    exp_in8    = (exponentOut == 8'd0) ? 8'd1 : exponentOut;
    exp_in     = $signed({2'b00, exp_in8});
    is_special = (exponentOut == 8'hFF);
    is_zero    = ~carryOut & (alignedResult == 24'd0) & ~guardBit & ~roundBit & ~stickyBit;
    if (carryOut) begin
      // Right shift by one: the bit that falls off R joins the sticky bit
      work_load = {1'b1, alignedResult, guardBit, roundBit | stickyBit};
      exp_load  = exp_in + 10'sd1;
    end else begin
      work_load = {alignedResult, guardBit, roundBit, stickyBit};
      exp_load  = exp_in;
    end
    load_norm = work_load[26] | (exp_load == 10'sd1);
  end

`ifdef FPNORM_FAST_SHIFT_EN
  logic [4:0]        lzc;
  logic signed [9:0] exp_room;
  logic [9:0]        shamt;

  // Normalize in one step: leading zeros of {mant, G, R}, limited so E stays >= 1
  always_comb begin
    lzc = 5'd26;
    for (int i = 0; i < 26; i++) begin
      if (work[i+1]) lzc = 5'(25 - i);
    end
    exp_room = exp_q - 10'sd1;
    if ($signed({5'b00000, lzc}) < exp_room) shamt = {5'b00000, lzc};
    else                                      shamt = $unsigned(exp_room);
    work_shift = {work[26:1] << shamt, work[0]};
    exp_shift  = exp_q - $signed(shamt);
    shift_done = 1'b1;
  end
`else
  // One-bit left shift: mant takes G, G takes R, R clears, sticky is kept
  always_comb begin
    work_shift = {work[25:1], 1'b0, work[0]};
    exp_shift  = exp_q - 10'sd1;
    shift_done = work_shift[26] | (exp_shift == 10'sd1);
  end
`endif

  // Round to nearest even; a mantissa carry-out renormalizes to 1.0 x 2^(E+1)
  always_comb begin
    mant     = work[26:3];
    round_up = work[2] & (work[1] | work[0] | mant[0]);
    inexact  = |work[2:0];
    sum      = {1'b0, mant} + {24'd0, round_up};
    if (sum[24]) begin
      mant_r = 24'h800000;
      exp_r  = exp_q + 10'sd1;
    end else begin
      mant_r = sum[23:0];
      exp_r  = exp_q;
    end
  end

  // Control FSM with registered result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      work               <= 27'd0;
      exp_q              <= 10'sd0;
      sign_q             <= 1'b0;
      out_valid          <= 1'b0;
      normalizedSign     <= 1'b0;
      normalizedExponent <= 8'd0;
      normalizedMantissa <= 23'd0;
      overflow           <= 1'b0;
      underflow          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_special) begin
              normalizedSign     <= alignedSign;
              normalizedExponent <= 8'hFF;
              normalizedMantissa <= alignedResult[22:0];
              overflow           <= 1'b0;
              underflow          <= 1'b0;
              out_valid          <= 1'b1;
              state              <= DONE;
            end else if (is_zero) begin
              normalizedSign     <= 1'b0;
              normalizedExponent <= 8'd0;
              normalizedMantissa <= 23'd0;
              overflow           <= 1'b0;
              underflow          <= 1'b0;
              out_valid          <= 1'b1;
              state              <= DONE;
            end else begin
              work   <= work_load;
              exp_q  <= exp_load;
              sign_q <= alignedSign;
              state  <= load_norm ? ROUND : SHIFT;
            end
          end
        end
        SHIFT: begin
          work  <= work_shift;
          exp_q <= exp_shift;
          if (shift_done) state <= ROUND;
        end
        ROUND: begin
          normalizedSign <= sign_q;
          if (exp_r >= 10'sd255) begin
            normalizedExponent <= 8'hFF;
            normalizedMantissa <= 23'd0;
            overflow           <= 1'b1;
            underflow          <= 1'b0;
          end else if (!mant_r[23]) begin
            normalizedExponent <= 8'd0;
            normalizedMantissa <= mant_r[22:0];
            overflow           <= 1'b0;
            underflow          <= inexact;
          end else begin
            normalizedExponent <= exp_r[7:0];
            normalizedMantissa <= mant_r[22:0];
            overflow           <= 1'b0;
            underflow          <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_normalize_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_normalize_round
// Purpose  : Scoreboard bench for fp_normalize_round. It uses directed and
//            random operands with a reference model, random backpressure,
//            and an asynchronous reset during normalization.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] alignedResult;
  logic        carryOut;
  logic        alignedSign;
  logic [7:0]  exponentOut;
  logic        guardBit;
  logic        roundBit;
  logic        stickyBit;
  logic        out_valid;
  logic        out_ready;
  logic        normalizedSign;
  logic [7:0]  normalizedExponent;
  logic [22:0] normalizedMantissa;
  logic        overflow;
  logic        underflow;

  logic [33:0] dut_res;
  assign dut_res = {normalizedSign, normalizedExponent, normalizedMantissa, overflow, underflow};

  typedef struct {
    logic [33:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   bp_len = 0;

  fp_normalize_round dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .alignedResult      (alignedResult),
    .carryOut           (carryOut),
    .alignedSign        (alignedSign),
    .exponentOut        (exponentOut),
    .guardBit           (guardBit),
    .roundBit           (roundBit),
    .stickyBit          (stickyBit),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .normalizedSign     (normalizedSign),
    .normalizedExponent (normalizedExponent),
    .normalizedMantissa (normalizedMantissa),
    .overflow           (overflow),
    .underflow          (underflow)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value-level normalize then RNE. Result packed as {sign, exp, frac, ovf, unf}.
  function automatic void model(input logic c, input logic [23:0] a, input logic sg,
                                input logic [7:0] ex, input logic g, input logic r,
                                input logic s, output logic [33:0] res, output int lat);
    int          e;
    int          n;
    logic [25:0] v;
    logic        st;
    logic [2:0]  rem;
    logic        up;
    logic [24:0] m;
    if (ex == 8'd255) begin
      res = {sg, 8'hFF, a[22:0], 2'b00};
      lat = 1;
      return;
    end
    if (!c && a == 24'd0 && !g && !r && !s) begin
      res = '0;
      lat = 1;
      return;
    end
    e = (ex == 8'd0) ? 1 : int'(ex);
    n = 0;
    if (c) begin
      v  = {1'b1, a, g};
      st = r | s;
      e  = e + 1;
    end else begin
      v  = {a, g, r};
      st = s;
      while (!v[25] && e > 1) begin
        v = v << 1;
        e = e - 1;
        n = n + 1;
      end
    end
    rem = {v[1], v[0], st};
    up  = (rem > 3'b100) || (rem == 3'b100 && v[2]);
    m   = {1'b0, v[25:2]} + {24'd0, up};
    if (m[24]) begin
      m = 25'h0800000;
      e = e + 1;
    end
    if (e >= 255)    res = {sg, 8'hFF, 23'd0, 2'b10};
    else if (!m[23]) res = {sg, 8'd0, m[22:0], 1'b0, (rem != 3'b000)};
    else             res = {sg, 8'(e), m[22:0], 2'b00};
`ifdef FPNORM_FAST_SHIFT_EN
    lat = (n > 0) ? 3 : 2;
`else
    lat = 2 + n;
`endif
  endfunction

  // Issue one operand at a negedge and hold it until accepted. Push the expectation.
  task automatic send(input logic c, input logic [23:0] a, input logic sg, input logic [7:0] ex,
                      input logic g, input logic r, input logic s);
    exp_t x;
    int   w;
    carryOut      = c;
    alignedResult = a;
    alignedSign   = sg;
    exponentOut   = ex;
    guardBit      = g;
    roundBit      = r;
    stickyBit     = s;
    in_valid      = 1'b1;
    w = 0;
    while (!in_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    model(c, a, sg, ex, g, r, s, x.res, x.lat);
    x.acc = cyc;
    sb_q.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || out_valid) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sb_q.size());
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Monitor: drive out_ready, check hold stability, pop and compare on each handshake
  initial begin : monitor
    exp_t        x;
    logic [33:0] snap;
    bit          hold;
    bit          rel;
    bit          seen;
    bit          rdy;
    int          seen_cyc;
    int          low_cnt;
    hold = 0; rel = 0; seen = 0; seen_cyc = 0; low_cnt = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0; rel = 0; seen = 0; low_cnt = 0;
        out_ready = 1'b0;
        continue;
      end
      if (rel) begin
        chk("in_ready_after_release", {63'd0, in_ready}, 64'd1);
        chk("out_valid_after_release", {63'd0, out_valid}, 64'd0);
        rel = 0;
      end
      if (hold) begin
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_result", {30'd0, dut_res}, {30'd0, snap});
        hold = 0;
      end
      if (out_valid) begin
        if (!seen) begin
          seen     = 1;
          seen_cyc = cyc;
          chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
        end
        if (bp_len > 0) rdy = (low_cnt >= bp_len);
        else            rdy = ($urandom_range(0, 3) != 0);
        out_ready = rdy;
        if (rdy) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0h required=none", dut_res);
          end else begin
            x = sb_q.pop_front();
            chk("result", {30'd0, dut_res}, {30'd0, x.res});
            chk("latency", 64'(seen_cyc - x.acc), 64'(x.lat));
          end
          seen = 0; rel = 1; low_cnt = 0;
        end else begin
          snap = dut_res;
          hold = 1;
          low_cnt++;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #600000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    logic        c;
    logic [23:0] a;
    logic [7:0]  ex;
    logic        g, r, s;
    int          sel;
    rst_n = 1'b0; in_valid = 1'b0; alignedResult = '0; carryOut = 1'b0; alignedSign = 1'b0;
    exponentOut = '0; guardBit = 1'b0; roundBit = 1'b0; stickyBit = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_outputs", {30'd0, dut_res}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    send(1'b1, 24'h000000, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0);
    send(1'b0, 24'h200000, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0);
    send(1'b0, 24'h800001, 1'b0, 8'd100, 1'b1, 1'b0, 1'b0);
    send(1'b0, 24'h800000, 1'b1, 8'd100, 1'b1, 1'b0, 1'b0);
    send(1'b0, 24'hFFFFFF, 1'b0, 8'd254, 1'b1, 1'b0, 1'b0);
    send(1'b0, 24'h000010, 1'b0, 8'd3,   1'b0, 1'b0, 1'b0);
    send(1'b0, 24'h000000, 1'b1, 8'd50,  1'b0, 1'b0, 1'b0);
    send(1'b0, 24'h400001, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0);
    send(1'b0, 24'h000003, 1'b0, 8'd0,   1'b1, 1'b1, 1'b0);
    drain();

    // Backpressure: out_ready held low for five cycles
    bp_len = 5;
    send(1'b0, 24'h923456, 1'b1, 8'd80, 1'b1, 1'b1, 1'b0);
    drain();
    bp_len = 0;

    // Asynchronous reset during a long normalization
    send(1'b0, 24'h000001, 1'b1, 8'd127, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midshift_reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midshift_reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midshift_reset_outputs", {30'd0, dut_res}, 64'd0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random operands
    for (int k = 0; k < 200; k++) begin
      c   = ($urandom_range(0, 3) == 0);
      a   = 24'($urandom) >> $urandom_range(0, 24);
      sel = $urandom_range(0, 9);
      case (sel)
        0:       ex = 8'd0;
        1:       ex = 8'd1;
        2:       ex = 8'd2;
        3:       ex = 8'd254;
        4:       ex = 8'd255;
        default: ex = 8'($urandom_range(3, 253));
      endcase
      g = 1'($urandom);
      r = 1'($urandom);
      s = 1'($urandom);
      if (a == 24'd0 && !c && $urandom_range(0, 1) == 1) begin
        g = 1'b0; r = 1'b0; s = 1'b0;
      end
      send(c, a, 1'($urandom), ex, g, r, s);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
